// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes, lock FSM states and the
// stage-1 transition-minimisation rule used by both encoder and decoder.
package tmds_pkg;

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Expected q[8] for a byte: 0 selects the XNOR chain, 1 the XOR chain.
    function automatic logic tm_min_q8(input logic [7:0] data);
        logic [3:0] n1;
        n1 = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1 = n1 + {3'd0, data[i]};
        end
        if ((n1 > 4'd4) || ((n1 == 4'd4) && (data[0] == 1'b0))) begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/tmds_if.sv
// Symbol stream into the decoder and decoded stream/status out of it.
//
// Handshake: valid-only, no back-pressure. A symbol is taken on every
// rising clk edge where valid_in is 1. valid_out qualifies data_out,
// ctrl_out, de_out and err_out exactly two cycles later; locked_out,
// err_count_out and state_dbg are status and are meaningful every cycle.
interface tmds_if;
    import tmds_pkg::*;

    logic [9:0]  tmds_in;
    logic        valid_in;
    logic [7:0]  data_out;
    logic [1:0]  ctrl_out;
    logic        de_out;
    logic        valid_out;
    logic        err_out;
    logic        locked_out;
    logic [15:0] err_count_out;
    lock_state_t state_dbg;

    modport master (
        output tmds_in, valid_in,
        input  data_out, ctrl_out, de_out, valid_out, err_out,
        input  locked_out, err_count_out, state_dbg
    );

    modport slave (
        input  tmds_in, valid_in,
        output data_out, ctrl_out, de_out, valid_out, err_out,
        output locked_out, err_count_out, state_dbg
    );

endinterface

// File: rtl/tmds_symbol_decode.sv
// Combinational second-stage decode: undoes the XOR/XNOR chain and flags
// symbols whose q[8] disagrees with what an encoder would have chosen.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [7:0] i_d,
    input  logic       i_q8,
    output logic [7:0] o_data,
    output logic       o_err
);

    logic [7:0] w_data;

    // Invert the stage-1 chain: each bit is recovered from adjacent d bits.
    always_comb begin
        w_data    = 8'd0;
        w_data[0] = i_d[0];
        for (int i = 1; i < 8; i++) begin
            w_data[i] = i_q8 ? (i_d[i] ^ i_d[i-1]) : ~(i_d[i] ^ i_d[i-1]);
        end
    end

    assign o_data = w_data;
    assign o_err  = (tm_min_q8(w_data) != i_q8);

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive decoder for one channel: 2-stage pipeline, control-token
// classification, encoding-rule check, link-lock FSM and error counter.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS = 8,
    parameter int ERR_LIMIT   = 4
)(
    input  logic clk_in,
    input  logic rst_in,
    tmds_if.slave bus
);

    localparam int TOK_W = $clog2(LOCK_TOKENS + 1);
    localparam int RUN_W = $clog2(ERR_LIMIT + 1);

    // Stage 1 registers
    logic        r_s1_valid;
    logic        r_s1_ctrl;
    logic [1:0]  r_s1_tok;
    logic [7:0]  r_s1_d;
    logic        r_s1_q8;

    // Stage 2 / output registers
    logic        r_valid_out;
    logic [7:0]  r_data_out;
    logic [1:0]  r_ctrl_out;
    logic        r_de_out;
    logic        r_err_out;
    logic [15:0] r_err_count;

    // Lock FSM
    lock_state_t      r_state;
    lock_state_t      w_state_nxt;
    logic [TOK_W-1:0] r_tok_cnt;
    logic [TOK_W-1:0] w_tok_nxt;
    logic [RUN_W-1:0] r_err_run;
    logic [RUN_W-1:0] w_run_nxt;

    logic        w_is_ctrl;
    logic [1:0]  w_tok;
    logic [7:0]  w_dec_data;
    logic        w_dec_err;
    logic        w_data_err;

    // Exact-match classification of the incoming symbol as a control token.
    always_comb begin
        w_is_ctrl = 1'b1;
        w_tok     = 2'b00;
        case (bus.tmds_in)
            CTRL_00: w_tok = 2'b00;
            CTRL_01: w_tok = 2'b01;
            CTRL_10: w_tok = 2'b10;
            CTRL_11: w_tok = 2'b11;
            default: w_is_ctrl = 1'b0;
        endcase
    end

    // Stage 1: capture the symbol; payload only loads on valid cycles.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_valid <= 1'b0;
            r_s1_ctrl  <= 1'b0;
            r_s1_tok   <= 2'b00;
            r_s1_d     <= 8'd0;
            r_s1_q8    <= 1'b0;
        end else begin
            r_s1_valid <= bus.valid_in;
            if (bus.valid_in) begin
                r_s1_ctrl <= w_is_ctrl;
                r_s1_tok  <= w_tok;
                r_s1_d    <= bus.tmds_in[9] ? ~bus.tmds_in[7:0] : bus.tmds_in[7:0];
                r_s1_q8   <= bus.tmds_in[8];
            end
        end
    end

    tmds_symbol_decode u_symbol_decode (
        .i_d    (r_s1_d),
        .i_q8   (r_s1_q8),
        .o_data (w_dec_data),
        .o_err  (w_dec_err)
    );

    assign w_data_err = r_s1_valid && !r_s1_ctrl && w_dec_err;

    // Lock FSM next state; it advances on the same edge that publishes the
    // symbol, so locked_out changes together with valid_out.
    always_comb begin
        w_state_nxt = r_state;
        w_tok_nxt   = r_tok_cnt;
        w_run_nxt   = r_err_run;
        if (r_s1_valid) begin
            case (r_state)
                UNLOCKED: begin
                    w_run_nxt = '0;
                    if (r_s1_ctrl) begin
                        if (r_tok_cnt == TOK_W'(LOCK_TOKENS - 1)) begin
                            w_state_nxt = LOCKED;
                            w_tok_nxt   = '0;
                        end else begin
                            w_tok_nxt = r_tok_cnt + TOK_W'(1);
                        end
                    end else begin
                        w_tok_nxt = '0;
                    end
                end
                LOCKED: begin
                    w_tok_nxt = '0;
                    if (w_data_err) begin
                        if (r_err_run == RUN_W'(ERR_LIMIT - 1)) begin
                            w_state_nxt = UNLOCKED;
                            w_run_nxt   = '0;
                        end else begin
                            w_run_nxt = r_err_run + RUN_W'(1);
                        end
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = UNLOCKED;
                    w_tok_nxt   = '0;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    // Lock FSM state and run counters.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= UNLOCKED;
            r_tok_cnt <= '0;
            r_err_run <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tok_cnt <= w_tok_nxt;
            r_err_run <= w_run_nxt;
        end
    end

    // Stage 2: publish decoded symbol; fields hold across bubbles.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid_out <= 1'b0;
            r_data_out  <= 8'd0;
            r_ctrl_out  <= 2'b00;
            r_de_out    <= 1'b0;
            r_err_out   <= 1'b0;
        end else begin
            r_valid_out <= r_s1_valid;
            r_err_out   <= 1'b0;
            if (r_s1_valid) begin
                if (r_s1_ctrl) begin
                    r_de_out   <= 1'b0;
                    r_ctrl_out <= r_s1_tok;
                    r_data_out <= 8'd0;
                end else begin
                    r_de_out   <= 1'b1;
                    r_data_out <= w_dec_data;
                    r_err_out  <= w_dec_err;
                end
            end
        end
    end

    // Saturating count of errored data symbols, independent of lock state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_err_count <= 16'd0;
        end else if (w_data_err && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign bus.valid_out     = r_valid_out;
    assign bus.data_out      = r_data_out;
    assign bus.ctrl_out      = r_ctrl_out;
    assign bus.de_out        = r_de_out;
    assign bus.err_out       = r_err_out;
    assign bus.err_count_out = r_err_count;
    assign bus.locked_out    = (r_state == LOCKED);
    assign bus.state_dbg     = r_state;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: control/data decode, error flag, lock
// FSM sequences, bubbles, reset mid-stream and counter saturation.
module tb_tmds_decoder;
    import tmds_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_errs = 0;

    tmds_if bus();

    tmds_decoder #(
        .LOCK_TOKENS (8),
        .ERR_LIMIT   (4)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, then wait for the next falling edge.
    task automatic send(input logic [9:0] sym, input logic v);
        bus.tmds_in  = sym;
        bus.valid_in = v;
        @(negedge clk_in);
    endtask

    // Send one valid symbol and one bubble; outputs then show that symbol.
    task automatic put(input logic [9:0] sym);
        send(sym, 1'b1);
        send(10'h000, 1'b0);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] data, input logic [1:0] ctrl,
                           input logic de, input logic err);
        chk({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd1);
        chk({tag, "_data"},  {24'd0, bus.data_out}, {24'd0, data});
        chk({tag, "_ctrl"},  {30'd0, bus.ctrl_out}, {30'd0, ctrl});
        chk({tag, "_de"},    {31'd0, bus.de_out}, {31'd0, de});
        chk({tag, "_err"},   {31'd0, bus.err_out}, {31'd0, err});
    endtask

    initial begin
        bus.tmds_in  = 10'h000;
        bus.valid_in = 1'b0;
        rst_in       = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);

        // Reset state
        chk("rst_valid",  {31'd0, bus.valid_out}, 32'd0);
        chk("rst_data",   {24'd0, bus.data_out}, 32'd0);
        chk("rst_ctrl",   {30'd0, bus.ctrl_out}, 32'd0);
        chk("rst_de",     {31'd0, bus.de_out}, 32'd0);
        chk("rst_err",    {31'd0, bus.err_out}, 32'd0);
        chk("rst_locked", {31'd0, bus.locked_out}, 32'd0);
        chk("rst_cnt",    {16'd0, bus.err_count_out}, 32'd0);
        chk("rst_state",  {31'd0, bus.state_dbg}, {31'd0, UNLOCKED});
        rst_in = 1'b0;
        @(negedge clk_in);

        // Control tokens
        put(10'h354); chk_out("c00", 8'h00, 2'b00, 1'b0, 1'b0);
        put(10'h0AB); chk_out("c01", 8'h00, 2'b01, 1'b0, 1'b0);
        put(10'h154); chk_out("c10", 8'h00, 2'b10, 1'b0, 1'b0);
        put(10'h2AB); chk_out("c11", 8'h00, 2'b11, 1'b0, 1'b0);

        // Clean data; ctrl_out keeps the last token
        put(10'h100); chk_out("d100", 8'h00, 2'b11, 1'b1, 1'b0);
        put(10'h200); chk_out("d200", 8'hFF, 2'b11, 1'b1, 1'b0);

        // Errored data
        put(10'h155); exp_errs++;
        chk_out("d155", 8'hFF, 2'b11, 1'b1, 1'b1);
        chk("d155_cnt", {16'd0, bus.err_count_out}, exp_errs);

        // Latency and bubble: 100, X, 200
        send(10'h100, 1'b1);
        chk("lat_v0", {31'd0, bus.valid_out}, 32'd0);
        send('x, 1'b0);
        chk_out("bub_a", 8'h00, 2'b11, 1'b1, 1'b0);
        send(10'h200, 1'b1);
        chk("bub_v", {31'd0, bus.valid_out}, 32'd0);
        chk("bub_data", {24'd0, bus.data_out}, 32'h00);
        chk("bub_de", {31'd0, bus.de_out}, 32'd1);
        chk("bub_err", {31'd0, bus.err_out}, 32'd0);
        send(10'h000, 1'b0);
        chk_out("bub_c", 8'hFF, 2'b11, 1'b1, 1'b0);
        send(10'h000, 1'b0);

        // Lock: 7 tokens, data breaks the run, then 8 tokens
        for (int i = 0; i < 7; i++) begin
            put(10'h354);
            chk("lock_run1", {31'd0, bus.locked_out}, 32'd0);
        end
        put(10'h100);
        chk("lock_brk", {31'd0, bus.locked_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            put(10'h354);
            chk("lock_run2", {31'd0, bus.locked_out}, (i == 7) ? 32'd1 : 32'd0);
        end
        chk("lock_state", {31'd0, bus.state_dbg}, {31'd0, LOCKED});

        // Four consecutive errors drop lock on the fourth
        for (int i = 0; i < 4; i++) begin
            put(10'h155); exp_errs++;
            chk("unlock", {31'd0, bus.locked_out}, (i == 3) ? 32'd0 : 32'd1);
        end
        chk("unlock_cnt", {16'd0, bus.err_count_out}, exp_errs);

        // Relock, then interrupted error runs keep lock
        for (int i = 0; i < 8; i++) begin
            put(10'h354);
            chk("relock", {31'd0, bus.locked_out}, (i == 7) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            put(10'h155); exp_errs++;
            chk("hold_a", {31'd0, bus.locked_out}, 32'd1);
        end
        put(10'h100);
        chk("hold_clean", {31'd0, bus.locked_out}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            put(10'h155); exp_errs++;
            chk("hold_b", {31'd0, bus.locked_out}, 32'd1);
        end
        chk("hold_cnt", {16'd0, bus.err_count_out}, exp_errs);

        // Reset mid-stream while locked
        send(10'h100, 1'b1);
        send(10'h155, 1'b1);
        rst_in = 1'b1;
        bus.tmds_in = 10'h354;
        @(negedge clk_in);
        chk("mrst_valid",  {31'd0, bus.valid_out}, 32'd0);
        chk("mrst_data",   {24'd0, bus.data_out}, 32'd0);
        chk("mrst_ctrl",   {30'd0, bus.ctrl_out}, 32'd0);
        chk("mrst_de",     {31'd0, bus.de_out}, 32'd0);
        chk("mrst_err",    {31'd0, bus.err_out}, 32'd0);
        chk("mrst_locked", {31'd0, bus.locked_out}, 32'd0);
        chk("mrst_cnt",    {16'd0, bus.err_count_out}, 32'd0);
        rst_in = 1'b0;
        send(10'h000, 1'b0);
        chk("mrst_v2", {31'd0, bus.valid_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            put(10'h354);
            chk("post_rst_lock", {31'd0, bus.locked_out}, (i == 7) ? 32'd1 : 32'd0);
        end

        // Saturation of the error counter
        for (int i = 0; i < 65534; i++) begin
            send(10'h155, 1'b1);
        end
        send(10'h000, 1'b0);
        send(10'h000, 1'b0);
        chk("sat_below", {16'd0, bus.err_count_out}, 32'h0000FFFE);
        put(10'h155);
        chk("sat_hit", {16'd0, bus.err_count_out}, 32'h0000FFFF);
        for (int i = 0; i < 4465; i++) begin
            send(10'h155, 1'b1);
        end
        send(10'h000, 1'b0);
        send(10'h000, 1'b0);
        chk("sat_hold", {16'd0, bus.err_count_out}, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
